// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit: 32-step shift-add multiply and restoring
// divide on a shared 2*XLEN accumulator, with architectural HI/LO registers.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            div_by_zero
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

    state_t            state;
    logic [CNT_W-1:0]  counter;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   m;
    logic [XLEN-1:0]   a_orig;
    logic              is_div, neg_res, neg_rem, dz;

    logic              sgn;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     add_sum, trial;
    logic [2*XLEN-1:0] acc_next, prod_fix;
    logic [XLEN-1:0]   q_fix, r_fix;

    // Signed ops run on magnitudes; signs are restored in FIX.
    always_comb begin
        sgn   = ~op[0];
        a_mag = (sgn && operand_a[XLEN-1]) ? -operand_a : operand_a;
        b_mag = (sgn && operand_b[XLEN-1]) ? -operand_b : operand_b;
    end

    // m holds the multiplicand (mult) or divisor (div).
    always_comb begin
        add_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, m} : '0);
        trial   = acc[2*XLEN-1:XLEN-1] - {1'b0, m};
        if (is_div)
            acc_next = trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                   : {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else
            acc_next = {add_sum, acc[XLEN-1:1]};
        prod_fix = neg_res ? -acc : acc;
        q_fix    = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        r_fix    = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            counter     <= '0;
            acc         <= '0;
            m           <= '0;
            a_orig      <= '0;
            is_div      <= 1'b0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            dz          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (!op[2]) begin
                            is_div  <= op[1];
                            dz      <= op[1] && (operand_b == '0);
                            neg_res <= sgn && (operand_a[XLEN-1] ^ operand_b[XLEN-1]);
                            neg_rem <= sgn && operand_a[XLEN-1];
                            a_orig  <= operand_a;
                            m       <= op[1] ? b_mag : a_mag;
                            acc     <= {{XLEN{1'b0}}, (op[1] ? a_mag : b_mag)};
                            counter <= '0;
                            busy    <= 1'b1;
                            state   <= RUN;
                        end else if (op == 3'b100) begin
                            hi <= operand_a;
                        end else if (op == 3'b101) begin
                            lo <= operand_a;
                        end
                    end
                end
                RUN: begin
                    acc     <= acc_next;
                    counter <= counter + 1'b1;
                    if (counter == LAST) begin
                        counter <= '0;
                        state   <= FIX;
                    end
                end
                FIX: begin
                    // Divide by zero reports the raw dividend regardless of signedness.
                    if (dz) begin
                        hi <= a_orig;
                        lo <= '1;
                    end else if (is_div) begin
                        hi <= r_fix;
                        lo <= q_fix;
                    end else begin
                        hi <= prod_fix[2*XLEN-1:XLEN];
                        lo <= prod_fix[XLEN-1:0];
                    end
                    div_by_zero <= dz;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO/flag queued at issue,
// compared by a monitor on each done pulse.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sp;
        logic [63:0] up;
        int          sq, sr;
        e.dz = 1'b0;
        e.hi = '0;
        e.lo = '0;
        case (o)
            3'b000: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                e.hi = sp[63:32];
                e.lo = sp[31:0];
            end
            3'b001: begin
                up = {32'b0, a} * {32'b0, b};
                e.hi = up[63:32];
                e.lo = up[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    e.hi = a;
                    e.lo = 32'hFFFF_FFFF;
                    e.dz = 1'b1;
                end else if (o == 3'b010 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.hi = 32'd0;
                    e.lo = 32'h8000_0000;
                end else if (o == 3'b010) begin
                    sq = $signed(a) / $signed(b);
                    sr = $signed(a) % $signed(b);
                    e.hi = sr;
                    e.lo = sq;
                end else begin
                    e.hi = a % b;
                    e.lo = a / b;
                end
            end
        endcase
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("hi", {32'b0, hi}, {32'b0, e.hi});
                chk("lo", {32'b0, lo}, {32'b0, e.lo});
                chk("dz", {63'b0, div_by_zero}, {63'b0, e.dz});
            end
        end
    end

    // Issue one mult/div, push its expectation, then track busy/done timing.
    // With inject set, an MTLO start is pulsed mid-run and must be ignored.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit inject);
        int k, busy_cnt;
        bit seen;
        @(negedge clk);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        sb.push_back(model(o, a, b));
        @(posedge clk);
        #1;
        start = 1'b0;
        operand_a = ~a; operand_b = ~b;
        busy_cnt = 0;
        seen = 0;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) busy_cnt++;
            if (inject && k == 5) begin
                start = 1'b1; op = 3'b101; operand_a = 32'hAAAA_5555;
            end else if (inject && k == 6) begin
                start = 1'b0;
            end
        end
        chk("done_seen", {63'b0, seen}, 64'd1);
        chk("latency", 64'(k), 64'd33);
        chk("busy_cycles", 64'(busy_cnt), 64'd33);
        chk("busy_at_done", {63'b0, busy}, 64'd0);
        @(negedge clk);
        chk("done_pulse_width", {63'b0, done}, 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  ro;
        #12;
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_dz", {63'b0, div_by_zero}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'b000, 32'hFFFF_FFF9, 32'h0000_0003, 0);
        run_op(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 0);
        run_op(3'b011, 32'd100, 32'd7, 0);
        run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'b011, 32'd1234, 32'd0, 0);
        run_op(3'b001, 32'd2, 32'd3, 0);
        run_op(3'b010, 32'hFFFF_FFFB, 32'd0, 0);
        run_op(3'b000, 32'h8000_0000, 32'h8000_0000, 0);

        for (int i = 0; i < 8; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : $urandom >> $urandom_range(0, 31);
            run_op(ro, ra, rb, 0);
        end

        // MTHI / MTLO on back-to-back idle edges.
        @(negedge clk);
        start = 1'b1; op = 3'b100; operand_a = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        chk("mthi_hi", {32'b0, hi}, {32'b0, 32'hDEAD_BEEF});
        chk("mthi_busy_done", {62'b0, busy, done}, 64'd0);
        @(negedge clk);
        op = 3'b101; operand_a = 32'h1234_5678;
        @(posedge clk); #1;
        chk("mtlo_lo", {32'b0, lo}, {32'b0, 32'h1234_5678});
        chk("mtlo_hi_hold", {32'b0, hi}, {32'b0, 32'hDEAD_BEEF});
        chk("mtlo_busy_done", {62'b0, busy, done}, 64'd0);
        @(negedge clk);
        op = 3'b110; operand_a = 32'h0BAD_0BAD;
        @(posedge clk); #1;
        chk("reserved_hilo", {hi, lo}, {32'hDEAD_BEEF, 32'h1234_5678});
        chk("reserved_busy", {63'b0, busy}, 64'd0);
        start = 1'b0;

        // MTLO while busy is dropped; lo ends with the MULTU product.
        run_op(3'b001, 32'd1000, 32'd77, 1);

        // Reset mid-run: immediate clear and no done for the aborted op.
        @(negedge clk);
        start = 1'b1; op = 3'b001; operand_a = 32'h1234_5678; operand_b = 32'h9ABC_DEF0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre_abort_busy", {63'b0, busy}, 64'd1);
        reset = 1'b0;
        #1;
        chk("abort_busy", {63'b0, busy}, 64'd0);
        chk("abort_done", {63'b0, done}, 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (50) @(negedge clk);
        chk("abort_idle", {62'b0, busy, done}, 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        chk("global_timeout", 64'd1, 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath.
- Sits directly downstream of the register file. Operands come from its two read ports (rs, rt).
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- HI/LO are exposed continuously so the writeback mux can serve MFHI/MFLO. `busy` lets the control unit stall dependent instructions.

Parameters:
- XLEN, 32, operand/HI/LO width.
- CNT_W, 5, iteration counter width (log2 XLEN).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  issue strobe. Sampled only while idle.
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 reserved.
- operand_a  input  XLEN  rs read data (multiplicand/dividend, or MTHI/MTLO source).
- operand_b  input  XLEN  rt read data (multiplier/divisor).
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when HI/LO are updated by a mult/div.
- hi  output  XLEN  HI register.
- lo  output  XLEN  LO register.
- div_by_zero  output  1  set with done when the last DIV/DIVU had divisor 0; cleared with done of the next mult/div.

Behaviour:
- Reset (reset=0, async): state IDLE; busy=0, done=0, hi=0, lo=0, div_by_zero=0, counter=0. Any operation in progress is aborted with no partial HI/LO update.
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 with op MULT/MULTU/DIV/DIVU: latch operands and signedness, then go to RUN with counter=0 and busy=1.
  - Signed ops latch operand magnitudes plus result sign flags.
  - start=1 with MTHI/MTLO: hi (or lo) takes operand_a at that edge. Stay IDLE; busy and done remain 0.
  - Reserved op, or start=0: no state change.
- RUN: one iteration per clock, XLEN iterations total. Counter wraps from 31 to 0 and the state moves to FIX.
  - Multiply: shift-add on a 2*XLEN accumulator.
  - Divide: restoring division; remainder in the upper half, quotient shifted into the lower half.
- FIX (one cycle):
  - Apply sign correction.
  - Signed MULT negates the 64-bit product when the operand signs differ.
  - Signed DIV negates the quotient when the signs differ; the remainder takes the dividend's sign.
  - Write hi/lo, pulse done=1, set busy=0, return to IDLE.
- Latency: start edge T0. busy is high after T0 through T33. hi/lo/done update at T33, i.e. 33 cycles after issue. done is high for exactly the cycle after T33.
- Result mapping:
  - MULT/MULTU: hi = upper 32 bits of the product, lo = lower 32 bits.
  - DIV/DIVU: lo = quotient, hi = remainder.
- Divide by zero:
  - Full 33-cycle latency.
  - lo = 32'hFFFFFFFF, hi = operand_a as issued (signed and unsigned alike).
  - div_by_zero=1.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. No flag.
- start while busy: ignored entirely; operands are not re-latched. The control unit is required to stall instead.
- Operands are sampled only at the issue edge. Later changes on operand_a/operand_b have no effect.
- hi/lo hold their values between updates. During RUN/FIX they show the previous results until T33.

Test Plan:
- Reset low mid-RUN (cycle 10 of MULTU) → busy=0, done=0, hi=lo=0 immediately. After release, no done pulse ever occurs for the aborted op.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → done at T0+33, hi=0xFFFFFFFE, lo=0x00000001, busy high for exactly 33 cycles.
- MULT −7 × 3 (0xFFFFFFF9, 0x00000003) → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV −7 / 2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). DIVU 100 / 7 → lo=14, hi=2. DIV 0x80000000 / −1 → lo=0x80000000, hi=0.
- DIVU 1234 / 0 → lo=0xFFFFFFFF, hi=1234, div_by_zero=1. A following MULTU 2×3 → hi=0, lo=6, div_by_zero=0.
- MTHI 0xDEADBEEF then MTLO 0x12345678 on consecutive idle cycles → hi/lo updated one edge each, busy/done never asserted. A start with MTLO during a MULTU is ignored and lo holds the MULTU result.
